cook_time_countdown: RTL

- Microwave cook-time register and countdown.
- Consumes the 100 ms enable pulse from the upstream hundred-millisecond counter.
- Accumulates TICKS_PER_SEC pulses into one second, then decrements a BCD MM:SS value.
- Drives that counter's enable, plus status and alarm outputs to the control FSM and the display stage.

---
 rtl/cook_time_countdown.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cook_time_countdown.sv
// Microwave cook-time register and countdown.
// A sub-second counter collects TICKS_PER_SEC tick pulses, and each full
// second decrements a BCD MM:SS value. The counter reports RUNNING through
// tick_en/running, pulses done on reaching 00:00 and then holds alarm.
// Optional feature macro: QUICK_ADD_EN (the add pulse adds ADD_SECONDS).
// Handshake: all command inputs are single-cycle pulses that act on the next
// clock edge. When several coincide, the priority is
// clear > load > add > pause > start > tick.
// A command that is not legal in the current state is ignored, and the next
// command in priority order is evaluated instead.
module cook_time_countdown #(
  parameter int TICKS_PER_SEC = 10,
  parameter int ADD_SECONDS   = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       add,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       tick_en,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic [2:0] state_dbg
);

  localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READY   = 3'd1,
    S_RUNNING = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mm_q, mm_d, ss_q, ss_d;
  logic [SW-1:0] sub_q, sub_d;
  logic          done_q, done_d;
  logic          running_q, alarm_q;
  logic [7:0]    san_mm, san_ss;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // One BCD pair minus one; callers never pass 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
    else                return {v[7:4] - 4'd1, 4'd9};
  endfunction

`ifdef QUICK_ADD_EN
  function automatic int to_secs(input logic [7:0] m, input logic [7:0] s);
    return (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 + int'(s[7:4]) * 10 + int'(s[3:0]);
  endfunction

  // Seconds to BCD {mm,ss}, saturating at 99:59.
  function automatic logic [15:0] to_bcd(input int t);
    int c, m, s;
    c = (t > 5999) ? 5999 : t;
    m = c / 60;
    s = c % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  logic [15:0] add_sum;
  assign add_sum = (state_q == S_DONE) ? to_bcd(ADD_SECONDS)
                                       : to_bcd(to_secs(mm_q, ss_q) + ADD_SECONDS);
`else
  logic unused_add;
  assign unused_add = add;
`endif

  // Load sanitiser: digits clamp to 9, seconds above 59 clamp to 59.
  always_comb begin
    san_mm = {clamp_digit(load_mm[7:4]), clamp_digit(load_mm[3:0])};
    san_ss = {clamp_digit(load_ss[7:4]), clamp_digit(load_ss[3:0])};
    if (san_ss[7:4] > 4'd5) san_ss = 8'h59;
  end

  // Next-state, time value and sub-second counter in priority order.
  always_comb begin
    state_d = state_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    sub_d   = sub_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      mm_d    = 8'h00;
      ss_d    = 8'h00;
      sub_d   = '0;
    end else if (load && state_q != S_RUNNING) begin
      mm_d    = san_mm;
      ss_d    = san_ss;
      sub_d   = '0;
      state_d = ({san_mm, san_ss} == 16'h0000) ? S_IDLE : S_READY;
`ifdef QUICK_ADD_EN
    end else if (add) begin
      mm_d = add_sum[15:8];
      ss_d = add_sum[7:0];
      if (state_q == S_IDLE || state_q == S_DONE) state_d = S_READY;
`endif
    end else if (pause && state_q == S_RUNNING) begin
      state_d = S_PAUSED;
    end else if (start && (state_q == S_READY || state_q == S_PAUSED)) begin
      state_d = S_RUNNING;
    end else if (tick && state_q == S_RUNNING) begin
      if (sub_q != SUB_LAST) begin
        sub_d = sub_q + 1'b1;
      end else begin
        sub_d = '0;
        if (ss_q != 8'h00) begin
          ss_d = bcd_dec(ss_q);
        end else begin
          ss_d = 8'h59;
          mm_d = bcd_dec(mm_q);
        end
        if (mm_d == 8'h00 && ss_d == 8'h00) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // State and output registers; reset aborts straight to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mm_q      <= 8'h00;
      ss_q      <= 8'h00;
      sub_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      sub_q     <= sub_d;
      done_q    <= done_d;
      running_q <= (state_d == S_RUNNING);
      alarm_q   <= (state_q == S_DONE) && (state_d == S_DONE);
    end
  end

  assign mm        = mm_q;
  assign ss        = ss_q;
  assign tick_en   = running_q;
  assign running   = running_q;
  assign done      = done_q;
  assign alarm     = alarm_q;
  assign state_dbg = state_q;

endmodule
